// File: rtl/fifo_stream_rd_pkg.sv
// fifo_stream_rd_pkg: shared types and helpers for the FIFO read-side drain path.
// Contents: rd_state_t (FETCH/DRAIN encoding), cnt_width() for sizing beat counters.
package fifo_stream_rd_pkg;

  // FETCH issues FIFO reads; DRAIN only empties what is already buffered or in flight.
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // Smallest counter width able to index n beats (minimum 1 bit).
  function automatic int cnt_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/fifo_stream_rd_buf.sv
// stream_buf2: 2-entry in-order buffer with registered head.
// Ports: clk, rst (sync, active-high); push_vld/push_dat write side;
//        pop advances the head; occ = 0..2; head_vld/head_dat expose the oldest entry.
module stream_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);
  // Purpose: hold up to two beats in arrival order, head always in ent0.
  // Latency: a pushed beat is visible at the head the cycle after the push.
  // Backpressure: head holds stable until popped; caller must not push into a full buffer.

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             pop_ok;

  // A pop on an empty buffer is ignored so the block is safe to reuse elsewhere.
  assign pop_ok   = pop & (occ != 2'd0);
  assign head_vld = (occ != 2'd0);
  assign head_dat = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push_vld, pop_ok})
        2'b10: begin
          if (occ != 2'd2) begin
            if (occ == 2'd0) ent0 <= push_dat;
            else             ent1 <= push_dat;
            occ <= occ + 2'd1;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new beat lands behind whatever remains.
          if (occ == 2'd1) begin
            ent0 <= push_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: read-domain drain controller between the async FIFO and a valid/ready stream.
// Ports: clk, rst (sync, active-high); run; fifo_empty/fifo_en/fifo_dout to the FIFO read port;
//        m_valid/m_ready/m_data/m_last stream out; beat_cnt = head index in burst; busy.
module fifo_stream_rd
  import fifo_stream_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = cnt_width(BURST_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             fifo_empty,
  output logic             fifo_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);
  // Purpose: pop the FIFO only when data exists and the local 2-entry buffer has room.
  // Latency: 2 cycles from fifo_en to m_valid; then 1 beat/cycle under continuous m_ready.
  // Backpressure: m_ready low stops reads once buffer + in-flight read reach 2 beats.

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  rd_state_t  state;
  logic       rst_q;
  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] committed;

  assign pop       = m_valid & m_ready;
  assign committed = {1'b0, occ} + {2'b00, inflight};

  // Room test is occ + inflight - pop < 2, rearranged so the 3-bit sum never underflows.
  // rst_q keeps reads off for the first cycle after reset release.
  assign fifo_en = run & ~fifo_empty & ~rst & ~rst_q
                 & (committed < (3'd2 + {2'b00, pop}));

  stream_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight),
    .push_dat (fifo_dout),
    .pop      (pop),
    .occ      (occ),
    .head_vld (m_valid),
    .head_dat (m_data)
  );

  assign m_last = m_valid & (beat_cnt == LAST_BEAT);
  assign busy   = (occ != 2'd0) | inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      rst_q    <= 1'b1;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      rst_q    <= 1'b0;
      inflight <= fifo_en;
      case (state)
        FETCH:   if (!run) state <= DRAIN;
        DRAIN:   if (run)  state <= FETCH;
        default: state <= FETCH;
      endcase
      // Burst position survives run toggling so bursts may straddle a drain.
      if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // Buffer plus in-flight read can never exceed the two buffer slots,
  // and a draining controller never issues a read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (committed <= 3'd2);
      if (state == DRAIN && !run) assert (!fifo_en);
    end
  end

endmodule

// File: tb/tb_fifo_stream_rd.sv
// tb_fifo_stream_rd: directed bench for fifo_stream_rd with a queue-based reference model.
// The model tracks words popped from the FIFO but not yet delivered, each stamped with its issue cycle.
module tb_fifo_stream_rd;

  localparam int BL = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       fifo_empty;
  logic       fifo_en;
  logic [7:0] fifo_dout = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [3:0] beat_cnt;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // FIFO stand-in: words mem[0..fill-1] have been written; rd_idx is its read pointer.
  logic [7:0] mem [0:127];
  int fill   = 0;
  int rd_idx = 0;

  assign fifo_empty = (rd_idx >= fill);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_en === 1'b1) begin
      fifo_dout <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  fifo_stream_rd #(
    .WIDTH(8),
    .BURST_LEN(BL),
    .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .fifo_empty (fifo_empty),
    .fifo_en    (fifo_en),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .beat_cnt   (beat_cnt),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t       q[$];
  int         cyc = 0;
  int         cnt = 0;
  bit         hold = 1'b0;
  bit         chk_on = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    bit   mv_e;
    bit   pop_e;
    bit   en_e;
    ent_t e;
    mv_e  = 1'b0;
    pop_e = 1'b0;
    if (chk_on) begin
      // A word fetched in cycle t is deliverable from cycle t+2 onward.
      mv_e  = (q.size() != 0) && (q[0].t <= cyc - 2);
      pop_e = mv_e && (m_ready === 1'b1);
      en_e  = run && !fifo_empty && !rst && !hold
              && ((q.size() - (pop_e ? 1 : 0)) < 2);
      chk("m_valid", m_valid, mv_e);
      if (mv_e) chk("m_data", m_data, q[0].d);
      chk("m_last", m_last, mv_e && (cnt == BL - 1));
      chk("beat_cnt", beat_cnt, cnt);
      chk("busy", busy, q.size() != 0);
      chk("fifo_en", fifo_en, en_e);
      chk("outstanding_le2", q.size() <= 2, 1);
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, data_prev);
      end
    end
    if (rst === 1'b1) begin
      q.delete();
      cnt        = 0;
      hold       = 1'b1;
      chk_on     = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (pop_e) begin
        e   = q.pop_front();
        cnt = (cnt + 1) % BL;
      end
      if (fifo_en === 1'b1) begin
        e.d = mem[rd_idx];
        e.t = cyc;
        q.push_back(e);
      end
      hold       = 1'b0;
      stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
      data_prev  = m_data;
    end
    cyc++;
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    int nb;
    int first_c;
    int last_c;
    int nlast;
    int n_en;

    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    rst = 1'b1; run = 1'b1; m_ready = 1'b1; fill = 32;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_en", fifo_en, 0);

    // 1 + 2: release with data waiting, 32 beats at full rate
    step();
    rst = 1'b0;
    nb = 0; first_c = -1; last_c = -1; nlast = 0;
    for (int k = 0; k < 60 && nb < 32; k++) begin
      if (k > 0) step();
      @(negedge clk);
      if (k == 0) chk("t1_en_cyc0", fifo_en, 0);
      if (k == 1) chk("t1_en_cyc1", fifo_en, 1);
      if (k == 2) chk("t1_valid_cyc2", m_valid, 0);
      if (k == 3) begin
        chk("t1_valid_cyc3", m_valid, 1);
        chk("t1_data_cyc3", m_data, 8'h00);
      end
      if (m_valid && m_ready) begin
        if (first_c < 0) first_c = k;
        last_c = k;
        if (m_last) begin
          nlast++;
          chk("t2_last_data", (m_data == 8'h0F) || (m_data == 8'h1F), 1);
        end
        if (nb == 16) chk("t2_wrap_cnt", beat_cnt, 0);
        chk("t2_order", m_data, 8'(nb));
        nb++;
      end
    end
    chk("t2_count", nb, 32);
    chk("t2_first_cycle", first_c, 3);
    chk("t2_last_cycle", last_c, 34);
    chk("t2_nlast", nlast, 2);

    // 3: m_ready 1,0,0,1 pattern
    nb = 0;
    for (int k = 0; k < 200 && nb < 32; k++) begin
      step();
      if (k == 0) fill = 64;
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk);
      if (m_valid && m_ready) begin
        chk("t3_order", m_data, 8'(32 + nb));
        nb++;
      end
    end
    chk("t3_count", nb, 32);

    // 4: long stall, then full-rate resume
    step();
    m_ready = 1'b0;
    fill = 80;
    n_en = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      @(negedge clk);
      if (fifo_en) n_en++;
    end
    chk("t4_reads_while_stalled", n_en, 2);
    nb = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) m_ready = 1'b1;
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (nb == 0) chk("t4_first_data", m_data, 8'h40);
        nb++;
      end
    end
    chk("t4_gapless_beats", nb, 16);

    // 5: drop run with one word buffered and one in flight
    step();
    m_ready = 1'b0;
    fill = 88;
    @(negedge clk);
    chk("t5_en_c0", fifo_en, 1);
    step();
    @(negedge clk);
    chk("t5_en_c1", fifo_en, 1);
    step();
    run = 1'b0;
    @(negedge clk);
    chk("t5_valid_c2", m_valid, 1);
    chk("t5_busy_c2", busy, 1);
    chk("t5_en_c2", fifo_en, 0);
    n_en = 0; nb = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) m_ready = 1'b1;
      @(negedge clk);
      if (fifo_en) n_en++;
      if (m_valid && m_ready) begin
        chk("t5_drain_data", m_data, 8'(80 + nb));
        nb++;
      end
    end
    chk("t5_no_reads", n_en, 0);
    chk("t5_drained", nb, 2);
    chk("t5_idle_busy", busy, 0);
    chk("t5_cnt_kept", beat_cnt, 2);
    nb = 0;
    for (int k = 0; k < 20 && nb < 6; k++) begin
      step();
      if (k == 0) run = 1'b1;
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (nb == 0) begin
          chk("t5_resume_data", m_data, 8'h52);
          chk("t5_resume_cnt", beat_cnt, 2);
        end
        nb++;
      end
    end
    chk("t5_resume_count", nb, 6);

    // 6: reset with the buffer full
    step();
    m_ready = 1'b0;
    fill = 96;
    repeat (3) step();
    @(negedge clk);
    chk("t6_busy_full", busy, 1);
    chk("t6_head_data", m_data, 8'h58);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_en_in_rst", fifo_en, 0);
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid_after", m_valid, 0);
    chk("t6_cnt_after", beat_cnt, 0);
    chk("t6_busy_after", busy, 0);
    chk("t6_en_after", fifo_en, 0);
    nb = 0;
    for (int k = 0; k < 20 && nb < 6; k++) begin
      step();
      @(negedge clk);
      if (m_valid && m_ready) begin
        chk("t6_data", m_data, 8'(90 + nb));
        nb++;
      end
    end
    chk("t6_count", nb, 6);

    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (%0d tests, %0d failed)", tests, fails);
    $fatal(1);
  end

endmodule
